// File: rtl/lease_table_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : lease_table_loader_if
// Purpose  : Bundles the stream handshake and table/config write bus of the
//            lease table loader. Signal suffixes are named from the loader's
//            point of view (_i = into the loader, _o = out of the loader).
// Signals  : start_i, data_i[31:0], valid_i      - load request and stream
//            ready_o                             - loader accepts a beat
//            con_wren_o                          - config register write strobe
//            llt_wren_o, llt_addr_o, llt_data_o  - lookup table write port
//            busy_o, done_o, error_o, count_o    - load status
// Modports : master (stream source / status sink), slave (the loader)
// Revision : 1.0 - initial release
// ============================================================================
interface lease_table_loader_if #(
  parameter int BW_ADDR_SPACE = 4
);
  logic                     start_i;
  logic [31:0]              data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic                     con_wren_o;
  logic                     llt_wren_o;
  logic [BW_ADDR_SPACE-1:0] llt_addr_o;
  logic [31:0]              llt_data_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     error_o;
  logic [BW_ADDR_SPACE:0]   count_o;

  modport master (
    output start_i, data_i, valid_i,
    input  ready_o, con_wren_o, llt_wren_o, llt_addr_o, llt_data_o,
           busy_o, done_o, error_o, count_o
  );

  modport slave (
    input  start_i, data_i, valid_i,
    output ready_o, con_wren_o, llt_wren_o, llt_addr_o, llt_data_o,
           busy_o, done_o, error_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/lease_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : lease_table_loader
// Purpose  : Loads a lease policy configuration word and a lease lookup table
//            from a 32-bit valid/ready stream. Stream layout:
//              header  {MAGIC[15:0], N[15:0]}   (1 <= N <= 4*N_ENTRIES)
//              default word -> config register  (con_wren_o)
//              N table words -> table addr 0..N-1 (llt_wren_o)
//              [checksum trailer, only with LEASE_LOADER_CHECKSUM_EN]
// Ports    : clock_i  - clock, all logic on posedge
//            resetn_i - synchronous active-low reset
//            bus      - lease_table_loader_if.slave (stream, write bus, status)
// Options  : LEASE_LOADER_CHECKSUM_EN - when defined, a trailer word equal to
//            the XOR of header, default and all table words is required.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef LEASE_LLT_ENTRIES
`define LEASE_LLT_ENTRIES 4
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module lease_table_loader #(
  parameter int          N_ENTRIES = `LEASE_LLT_ENTRIES,
  parameter logic [15:0] MAGIC     = 16'h1EA5
) (
  input  wire logic           clock_i,
  input  wire logic           resetn_i,
  lease_table_loader_if.slave bus
);

  localparam int          BW_ADDR_SPACE = `CLOG2(N_ENTRIES) + 2;
  localparam int unsigned WORDS         = 4 * N_ENTRIES;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_DEFAULT = 3'd2,
    S_TABLE   = 3'd3
`ifdef LEASE_LOADER_CHECKSUM_EN
    ,S_CHECK  = 3'd4
`endif
  } state_t;

  state_t                   state_q;
  logic                     ready_q;
  logic                     con_wren_q;
  logic                     llt_wren_q;
  logic [BW_ADDR_SPACE-1:0] llt_addr_q;
  logic [31:0]              llt_data_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     error_q;
  logic [BW_ADDR_SPACE:0]   count_q;
  logic [BW_ADDR_SPACE:0]   n_q;
`ifdef LEASE_LOADER_CHECKSUM_EN
  logic [31:0]              chk_q;
`endif

  logic                     beat;
  logic                     hdr_bad;
  logic [BW_ADDR_SPACE:0]   count_d;

  assign beat    = bus.valid_i & ready_q;
  assign count_d = count_q + 1'b1;
  // A valid N always fits in BW_ADDR_SPACE+1 bits, so the address counter
  // can never wrap once the header has passed this check.
  assign hdr_bad = (bus.data_i[31:16] != MAGIC) ||
                   (bus.data_i[15:0] == 16'd0) ||
                   ({16'd0, bus.data_i[15:0]} > WORDS);

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      con_wren_q <= 1'b0;
      llt_wren_q <= 1'b0;
      llt_addr_q <= '0;
      llt_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      n_q        <= '0;
`ifdef LEASE_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      // Strobes and done are single-cycle pulses unless re-asserted below.
      con_wren_q <= 1'b0;
      llt_wren_q <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // A start coinciding with the done pulse belongs to the load that
          // just ended and is dropped.
          if (bus.start_i && !done_q) begin
            state_q <= S_HEADER;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            count_q <= '0;
          end
        end

        S_HEADER: begin
          if (beat) begin
            if (hdr_bad) begin
              state_q <= S_IDLE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              n_q     <= bus.data_i[BW_ADDR_SPACE:0];
              state_q <= S_DEFAULT;
`ifdef LEASE_LOADER_CHECKSUM_EN
              chk_q   <= bus.data_i;
`endif
            end
          end
        end

        S_DEFAULT: begin
          if (beat) begin
            con_wren_q <= 1'b1;
            llt_addr_q <= '0;
            llt_data_q <= bus.data_i;
            state_q    <= S_TABLE;
`ifdef LEASE_LOADER_CHECKSUM_EN
            chk_q      <= chk_q ^ bus.data_i;
`endif
          end
        end

        S_TABLE: begin
          if (beat) begin
            llt_wren_q <= 1'b1;
            llt_addr_q <= count_q[BW_ADDR_SPACE-1:0];
            llt_data_q <= bus.data_i;
            count_q    <= count_d;
`ifdef LEASE_LOADER_CHECKSUM_EN
            chk_q      <= chk_q ^ bus.data_i;
`endif
            if (count_d == n_q) begin
`ifdef LEASE_LOADER_CHECKSUM_EN
              state_q <= S_CHECK;
`else
              // done lands in the same cycle as the final table strobe.
              state_q <= S_IDLE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
        end

`ifdef LEASE_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (beat) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= (bus.data_i != chk_q);
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.con_wren_o = con_wren_q;
  assign bus.llt_wren_o = llt_wren_q;
  assign bus.llt_addr_o = llt_addr_q;
  assign bus.llt_data_o = llt_data_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.error_o    = error_q;
  assign bus.count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lease_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lease_table_loader
// Purpose  : Self-checking bench for lease_table_loader. Header vectors are
//            table driven; every expected write is queued when its beat is
//            driven and matched against the strobes the loader produces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lease_table_loader;

  localparam int N_ENTRIES = 4;
  localparam int BW        = $clog2(N_ENTRIES) + 2;
  localparam int WORDS     = 4 * N_ENTRIES;

  logic clock_i  = 1'b0;
  logic resetn_i = 1'b0;

  always #5 clock_i = ~clock_i;

  lease_table_loader_if #(.BW_ADDR_SPACE(BW)) bus ();

  lease_table_loader #(
    .N_ENTRIES (N_ENTRIES),
    .MAGIC     (16'h1EA5)
  ) dut (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .bus      (bus)
  );

  typedef struct packed {
    logic          is_con;
    logic [BW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] dflt;
    logic [31:0] base;
    bit          gap;
    bit          exp_err;
  } vec_t;

  wr_t  sb[$];
  wr_t  mon_e;
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clock_i) begin
    if (bus.con_wren_o || bus.llt_wren_o) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {bus.con_wren_o, bus.llt_wren_o}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", {bus.con_wren_o, bus.llt_wren_o}, {mon_e.is_con, !mon_e.is_con});
        check("wr_addr", bus.llt_addr_o, mon_e.addr);
        check("wr_data", bus.llt_data_o, mon_e.data);
      end
    end
  end

  task automatic check_all_zero();
    check("z_ready", bus.ready_o, 0);
    check("z_con",   bus.con_wren_o, 0);
    check("z_llt",   bus.llt_wren_o, 0);
    check("z_busy",  bus.busy_o, 0);
    check("z_done",  bus.done_o, 0);
    check("z_error", bus.error_o, 0);
    check("z_addr",  bus.llt_addr_o, 0);
    check("z_data",  bus.llt_data_o, 0);
    check("z_count", bus.count_o, 0);
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    @(posedge clock_i); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit ok = 1'b0;
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock_i);
      if (bus.ready_o) begin
        ok = 1'b1;
        @(posedge clock_i); #1;
      end
    end
    check("beat_accepted", ok, 1);
  endtask

  task automatic finish_load(input bit exp_err, input int n);
    bit seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clock_i);
      if (bus.done_o) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_error", bus.error_o, exp_err);
      check("done_busy",  bus.busy_o, 0);
      check("done_ready", bus.ready_o, 0);
      if (!exp_err) check("done_count", bus.count_o, n);
      else          check("err_no_strobe", {bus.con_wren_o, bus.llt_wren_o}, 2'b00);
`ifndef LEASE_LOADER_CHECKSUM_EN
      if (!exp_err) check("done_with_last_wren", bus.llt_wren_o, 1);
`endif
      // A start in the done cycle must be ignored.
      bus.start_i = 1'b1;
      @(posedge clock_i); #1;
      bus.start_i = 1'b0;
      check("start_on_done_ignored", bus.busy_o, 0);
      @(negedge clock_i);
      check("done_one_cycle", bus.done_o, 0);
      check("error_sticky", bus.error_o, exp_err);
    end
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_load(input vec_t v, input bit corrupt);
    int          n   = int'(v.hdr[15:0]);
    logic [31:0] sum = v.hdr;
    logic [31:0] w;
    do_start();
    check("start_busy",    bus.busy_o, 1);
    check("start_ready",   bus.ready_o, 1);
    check("start_err_clr", bus.error_o, 0);
    check("start_count",   bus.count_o, 0);
    send_beat(v.hdr);
    if (!v.exp_err) begin
      sb.push_back('{1'b1, {BW{1'b0}}, v.dflt});
      send_beat(v.dflt);
      sum = sum ^ v.dflt;
      for (int k = 0; k < n; k++) begin
        w = v.base + k;
        sb.push_back('{1'b0, BW'(k), w});
        send_beat(w);
        sum = sum ^ w;
        if (v.gap && k != n - 1) begin
          // Idle gap with a stray start while busy.
          bus.valid_i = 1'b0;
          bus.start_i = 1'b1;
          @(posedge clock_i); #1;
          bus.start_i = 1'b0;
        end
      end
`ifdef LEASE_LOADER_CHECKSUM_EN
      send_beat(sum ^ {31'd0, corrupt});
`endif
    end
    bus.valid_i = 1'b0;
    finish_load(v.exp_err || corrupt, n);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;

    vecs[0] = '{32'h1EA5_0003, 32'h0000_0005, 32'h0000_000A, 1'b0, 1'b0};
    vecs[1] = '{32'hBEEF_0003, 32'h0000_0005, 32'h0000_000A, 1'b0, 1'b1};
    vecs[2] = '{32'h1EA5_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1};
    vecs[3] = '{{16'h1EA5, 16'(WORDS + 1)}, 32'h1, 32'h1, 1'b0, 1'b1};
    vecs[4] = '{{16'h1EA5, 16'(WORDS)}, 32'h0000_D00D, 32'h0000_1000, 1'b0, 1'b0};
    vecs[5] = '{32'h1EA5_0005, 32'h0000_0007, 32'hC0DE_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h1EA5_0001, 32'hFFFF_FFFF, 32'h55AA_55AA, 1'b0, 1'b0};
    vecs[7] = '{32'h1EA6_0002, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b1};

    repeat (3) @(posedge clock_i);
    #1;
    check_all_zero();
    resetn_i = 1'b1;
    @(posedge clock_i); #1;

    for (int i = 0; i < 8; i++) run_load(vecs[i], 1'b0);

    // Reset after table beat 1: the beat-1 strobe still appears, nothing after.
    do_start();
    send_beat(32'h1EA5_0003);
    sb.push_back('{1'b1, {BW{1'b0}}, 32'h11});
    send_beat(32'h11);
    sb.push_back('{1'b0, BW'(0), 32'h20});
    send_beat(32'h20);
    sb.push_back('{1'b0, BW'(1), 32'h21});
    send_beat(32'h21);
    bus.data_i  = 32'h22;
    resetn_i    = 1'b0;
    @(posedge clock_i); #1;
    bus.valid_i = 1'b0;
    check_all_zero();
    @(posedge clock_i); #1;
    resetn_i = 1'b1;
    @(negedge clock_i);
    check("rst_no_strobe", {bus.con_wren_o, bus.llt_wren_o}, 2'b00);
    check("rst_sb_drained", sb.size(), 0);
    sb.delete();
    run_load(vecs[0], 1'b0);

`ifdef LEASE_LOADER_CHECKSUM_EN
    run_load(vecs[6], 1'b1);
    run_load(vecs[0], 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lease_table_loader.md
LEASE_TABLE_LOADER -- requirements
Module: lease_table_loader

Interface
REQ-001 Parameter N_ENTRIES, default `LEASE_LLT_ENTRIES, entries per lease table; table word space = 4*N_ENTRIES.
REQ-002 Parameter MAGIC, default 16'h1EA5, required header tag.
REQ-003 Local BW_ADDR_SPACE = `CLOG2(N_ENTRIES)+2.
REQ-004 clock_i  input  1  sole clock; all logic on posedge.
REQ-005 resetn_i  input  1  reset, synchronous, active-low.
REQ-006 start_i  input  1  single-cycle request to begin a load; ignored while busy_o=1.
REQ-007 data_i  input  32  stream word.
REQ-008 valid_i  input  1  data_i valid.
REQ-009 ready_o  output  1  loader accepts data_i; a beat transfers on a posedge with valid_i&ready_o.
REQ-010 con_wren_o  output  1  configuration register write strobe, to lease policy controller con_wren_i.
REQ-011 llt_wren_o  output  1  lease lookup table write strobe, to llt_wren_i.
REQ-012 llt_addr_o  output  BW_ADDR_SPACE  write address, to llt_addr_i.
REQ-013 llt_data_o  output  32  write data, to llt_data_i.
REQ-014 busy_o  output  1  load in progress; cache holds off hit_i/miss_i while high.
REQ-015 done_o  output  1  one-cycle pulse at end of load (success or error).
REQ-016 error_o  output  1  sticky error flag; cleared by next accepted start_i.
REQ-017 count_o  output  BW_ADDR_SPACE+1  table words written in current/last load.

Function
REQ-018 States: IDLE, HEADER, DEFAULT, TABLE, CHECK (macro only); ready_o=1 only in HEADER/DEFAULT/TABLE/CHECK.
REQ-019 IDLE + start_i: go HEADER, busy_o=1, error_o=0, count_o=0 next cycle.
REQ-020 HEADER beat: N=data_i[15:0]; data_i[31:16]!=MAGIC, N==0 or N>4*N_ENTRIES -> error exit; else go DEFAULT.
REQ-021 DEFAULT beat: cycle after acceptance con_wren_o=1 for exactly one cycle, llt_addr_o=0, llt_data_o=beat; go TABLE.
REQ-022 TABLE beat k (k=0..N-1): cycle after acceptance llt_wren_o=1 for one cycle, llt_addr_o=k, llt_data_o=beat; count_o increments same cycle.
REQ-023 Throughput one beat per cycle; back-to-back beats give back-to-back strobes; valid_i gaps insert no strobes.
REQ-024 After beat N-1: go CHECK if macro defined, else IDLE with done_o pulse coincident with last llt_wren_o.
REQ-025 Error exit: next cycle state IDLE, error_o=1, done_o=1 for one cycle, busy_o=0, no strobe issued for the offending beat.
REQ-026 con_wren_o and llt_wren_o never high in the same cycle; strobes low when not writing; llt_addr_o/llt_data_o hold last value otherwise.
REQ-027 start_i while busy_o=1 has no effect; start_i in same cycle as done_o is ignored.
REQ-028 Address counter never wraps: N bounded by REQ-020, max address 4*N_ENTRIES-1.

Reset
REQ-029 resetn_i=0 at posedge: state IDLE; ready_o, con_wren_o, llt_wren_o, busy_o, done_o, error_o = 0; llt_addr_o, llt_data_o, count_o = 0.
REQ-030 Reset mid-load aborts immediately with no further strobes; already written table entries are not rolled back.

Configuration
REQ-031 Macro LEASE_LOADER_CHECKSUM_EN defined: running XOR over header, default and all table words; CHECK accepts one beat; mismatch -> error exit; match -> IDLE with done_o, error_o=0.
REQ-032 Macro undefined: no CHECK state, no checksum logic; load ends after table beat N-1.

Verification
REQ-033 start, header 0x1EA50003, default 0x00000005, table 0xA,0xB,0xC back-to-back -> con_wren addr0 data5, then llt_wren addr0/1/2 data A/B/C on consecutive cycles, done_o pulse, count_o=3, error_o=0.
REQ-034 header 0xBEEF0003 -> no strobes, done_o one cycle, error_o=1, busy_o=0; next start clears error_o.
REQ-035 header N=4*N_ENTRIES+1 and N=0 -> error exit; N=4*N_ENTRIES -> last llt_addr_o=4*N_ENTRIES-1, no error.
REQ-036 valid_i toggling every other cycle during TABLE -> strobes only after accepted beats, addresses contiguous; start_i mid-load ignored.
REQ-037 resetn_i low after table beat 1 -> all outputs zero next cycle, no further strobes, new start loads correctly.
REQ-038 LEASE_LOADER_CHECKSUM_EN: correct XOR trailer -> error_o=0; trailer XOR 1 -> error_o=1, done_o pulse.
